// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC/fetch block: FSM encoding, NOP, default vectors.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: JALR > taken branch/JAL > pc+4, plus the wrapping +4 adder.
// With PC_MISALIGN_TRAP_EN the raw target and a misalignment flag are returned; otherwise bits [1:0] are dropped.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic        jalr,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  logic [31:0] sel_pc;
  logic        unused_jalr_lsb;

  // JALR always clears bit 0 of rs1+imm before anything else looks at it.
  assign unused_jalr_lsb = jalr_target[0];

  always_comb begin
    pc_plus4 = pc + 32'd4;
    if (jalr) begin
      sel_pc = {jalr_target[31:1], 1'b0};
    end else if (pc_src) begin
      sel_pc = branch_target;
    end else begin
      sel_pc = pc_plus4;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign next_pc    = sel_pc;
  assign misaligned = sel_pc[1];
`else
  logic [1:0] unused_low_bits;

  assign unused_low_bits = sel_pc[1:0];
  assign next_pc         = {sel_pc[31:2], 2'b00};
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch FSM (IDLE -> FETCH -> EXEC) for the unpipelined core.
// Optional misaligned-target trap is compiled in with PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pc_src,
  input  logic         jalr,
  input  logic [31:0]  branch_target,
  input  logic [31:0]  jalr_target,
  input  logic         instr_done,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  output logic         instr_valid,
  output fetch_state_t dbg_state
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic         misalign_trap
`endif
);

  // Fetch handshake: imem_req and imem_addr are held stable from FETCH entry until the
  // cycle imem_ack is high; that cycle completes the transfer and imem_rdata is captured.
  // An ack in the first request cycle is legal; an ack seen outside FETCH is ignored.

  fetch_state_t state_q, state_d;
  logic         instr_load;
  logic         pc_load;
  logic [31:0]  next_pc;

`ifdef PC_MISALIGN_TRAP_EN
  logic         misaligned;
`endif

  pc_next_sel u_pc_next_sel (
    .pc            (pc),
    .pc_src        (pc_src),
    .jalr          (jalr),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  always_comb begin
    state_d    = state_q;
    instr_load = 1'b0;
    pc_load    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_load = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        // pc_src/jalr/targets only matter in the commit cycle.
        if (instr_done) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc      <= RESET_PC;
      instr   <= NOP;
    end else begin
      state_q <= state_d;
      if (instr_load) begin
        instr <= imem_rdata;
      end
      if (pc_load) begin
`ifdef PC_MISALIGN_TRAP_EN
        pc <= misaligned ? TRAP_PC : next_pc;
`else
        pc <= next_pc;
`endif
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // One-cycle pulse: the commit edge leaves EXEC, so pc_load cannot repeat next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= pc_load & misaligned;
    end
  end
`endif

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state_q == EXEC);
  assign dbg_state   = state_q;

endmodule
